// File: rtl/uart_pkg.sv
// UART receiver shared definitions: FSM state encoding, tick divisor, clog2 helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state to the encoding).
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   // Clocks per oversampling tick, integer floor.
   function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
      return int'(clk_hz / (baud * os));
   endfunction

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int clog2_f(input int v);
      int r = 0;
      int x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: register array with wrapping pointers and a registered head word.
// Latency: a push into an empty FIFO shows on head/!empty one cycle later.
// Backpressure: push while full without a pop is dropped; pop while empty is ignored.
// Ports: clk, rst, push/push_data (write), pop (consume head), head, full, empty, count.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [clog2_f(DEPTH):0]  count
);

   localparam int AW = clog2_f(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_nxt;
   logic [CW-1:0]    count_nxt;
   logic [WIDTH-1:0] head_nxt;
   logic             do_pop;
   logic             do_push;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_comb begin
      rd_nxt    = do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count_nxt = count + CW'(do_push) - CW'(do_pop);
      // The incoming word becomes the head only when it lands in the next read slot.
      if (do_push && (wr_ptr == rd_nxt))
         head_nxt = push_data;
      else
         head_nxt = mem[rd_nxt];
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_nxt;
         count  <= count_nxt;
         head   <= head_nxt;
      end
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop sync, oversampled 3-sample majority, frame checks, receive FIFO.
// Latency: word pushed 1 cycle after the final stop sample point, rx_valid 1 cycle after that.
// Backpressure: rx_valid/rx_ready handshake; a good word arriving with the FIFO full and no pop is dropped (overrun).
// Ports: clk, rst (async, active-high), rx (serial in), rx_data/rx_valid/rx_ready (output stream),
//        frame_err/parity_err/overrun (1-cycle pulses), busy, fifo_count.
// Optional feature macro: UART_RX_PARITY_EN (one parity bit after the data, parity_err live).
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun,
   output logic                          busy,
   output logic [clog2_f(FIFO_DEPTH):0]  fifo_count
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int DW  = clog2_f(DIV + 1);
   localparam int TW  = clog2_f(OVERSAMPLE);
   localparam int BW  = clog2_f(DATA_BITS + 1);

   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [TW-1:0] T_S0      = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_S1      = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_S2      = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   if (DIV < 1) begin : g_bad_div
      $error("uart_rx_cfg: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
   end
   if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
      $error("uart_rx_cfg: PARITY_ODD must be 0 or 1");
   end

   // Synchroniser and falling-edge detect
   logic rx_meta, rx_s, rx_s_d, fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_s_d  <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_s_d  <= rx_s;
      end
   end

   assign fall = rx_s_d & ~rx_s;

   // Receiver state
   state_t               state;
   logic [DW-1:0]        div_cnt;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic                 s0, s1;
   logic [DATA_BITS-1:0] shreg;
   logic                 fr_bad;
   logic                 push_vld;
   logic                 tick, samp0, samp1, samp2, bit_end, maj;
   logic                 stop_bad, word_bad;
   logic                 fifo_full, fifo_empty, pop;

   assign tick    = (div_cnt == DIV_LAST);
   assign samp0   = tick && (tick_cnt == T_S0);
   assign samp1   = tick && (tick_cnt == T_S1);
   assign samp2   = tick && (tick_cnt == T_S2);
   assign bit_end = tick && (tick_cnt == T_LAST);
   // Two stored samples plus the live third one.
   assign maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
   // Error status as it stands at the final stop sample point.
   assign stop_bad = fr_bad | ~maj;

`ifdef UART_RX_PARITY_EN
   logic par_bad;
   assign word_bad = stop_bad | par_bad;
`else
   assign word_bad   = stop_bad;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         div_cnt   <= '0;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         s0        <= 1'b1;
         s1        <= 1'b1;
         shreg     <= '0;
         fr_bad    <= 1'b0;
         push_vld  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         push_vld  <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (state == ST_IDLE) begin
            // Divider held at zero so tick phase starts from the detected edge.
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            fr_bad   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
            if (fall) begin
               state <= ST_START;
               busy  <= 1'b1;
            end
         end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick)
               tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
            if (samp0)
               s0 <= rx_s;
            if (samp1)
               s1 <= rx_s;

            case (state)
               ST_START: begin
                  if (samp2 && maj) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else if (bit_end) begin
                     state <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (samp2) begin
                     shreg   <= {maj, shreg[DATA_BITS-1:1]};
                     bit_cnt <= bit_cnt + BW'(1);
                  end
                  if (bit_end && bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                     state   <= ST_PARITY;
`else
                     state   <= ST_STOP;
`endif
                  end
               end
`ifdef UART_RX_PARITY_EN
               ST_PARITY: begin
                  if (samp2)
                     par_bad <= (maj != ((^shreg) ^ PARITY_ODD[0]));
                  if (bit_end)
                     state <= ST_STOP;
               end
`endif
               ST_STOP: begin
                  if (samp2) begin
                     if (bit_cnt == STOP_LAST) begin
                        // Leave at the sample point so a back-to-back start edge is not missed.
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        frame_err <= stop_bad;
                        push_vld  <= ~word_bad;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_bad;
`endif
                     end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                        fr_bad  <= stop_bad;
                     end
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rx_valid = ~fifo_empty;
   assign pop      = rx_valid & rx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overrun <= 1'b0;
      else
         overrun <= push_vld && fifo_full && !pop;
   end

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_vld),
      .push_data (shreg),
      .pop       (pop),
      .head      (rx_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frame-level model (expected word queue, expected flag counts)
// checked by one per-cycle compare process, plus literal expectations per scenario.
// Ports exercised: all; UART_RX_PARITY_EN adds the parity scenario.
module tb_uart_rx_cfg;

   localparam int  CLK_FREQ   = 6_400_000;
   localparam int  BAUD_RATE  = 100_000;
   localparam int  OS         = 16;
   localparam int  DEPTH      = 4;
   localparam bit  PAR_ODD    = 1'b0;
   localparam int  BIT        = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err, parity_err, overrun, busy;
   logic [2:0] fifo_count;

   uart_rx_cfg #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .OVERSAMPLE (OS),
      .DATA_BITS  (8),
      .STOP_BITS  (1),
      .FIFO_DEPTH (DEPTH),
      .PARITY_ODD (int'(PAR_ODD))
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int got_fe = 0, got_pe = 0, got_ov = 0;
   int exp_fe = 0, exp_pe = 0, exp_ov = 0;
   int valid_cycles = 0;
   logic [7:0] exp_q[$];
   logic [7:0] popped[$];
   bit fe_d = 0, pe_d = 0, ov_d = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Frame-level model: decides what the receiver must do with one whole frame.
   task automatic model_frame(input logic [7:0] d, input bit stop_low, input bit bad_par);
      if (stop_low)
         exp_fe++;
      else if (bad_par)
         exp_pe++;
      else if (exp_q.size() >= DEPTH)
         exp_ov++;
      else
         exp_q.push_back(d);
   endtask

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #2 rx_ready = v;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_low, input bit bad_par);
      model_frame(d, stop_low, bad_par);
      hold(1'b0, BIT);
      for (int i = 0; i < 8; i++)
         hold(d[i], BIT);
`ifdef UART_RX_PARITY_EN
      hold((^d) ^ PAR_ODD ^ bad_par, BIT);
`endif
      hold(~stop_low, BIT);
      hold(1'b1, 2 * BIT);
   endtask

   // Compare process: every pop against the model queue, flag pulses counted and width-checked.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid)
            valid_cycles++;
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL pop_unexpected: got 0x%0h, expected no word", rx_data);
            end else begin
               check("pop_data", rx_data, exp_q.pop_front());
            end
            popped.push_back(rx_data);
         end
         if (frame_err) begin
            got_fe++;
            check("frame_err_width", fe_d, 0);
         end
         if (parity_err) begin
            got_pe++;
            check("parity_err_width", pe_d, 0);
         end
         if (overrun) begin
            got_ov++;
            check("overrun_width", ov_d, 0);
         end
         fe_d = frame_err;
         pe_d = parity_err;
         ov_d = overrun;
      end
   end

   initial begin
      #600_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_rx_valid",   rx_valid,   0);
      check("rst_busy",       busy,       0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_rx_data",    rx_data,    0);
      check("rst_frame_err",  frame_err,  0);
      check("rst_parity_err", parity_err, 0);
      check("rst_overrun",    overrun,    0);
      rst = 1'b0;
      hold(1'b1, 20);

      // 1: single good frame, consumer always ready
      set_ready(1'b1);
      valid_cycles = 0;
      send_frame(8'hA5, 1'b0, 1'b0);
      check("t1_pop_count", popped.size(), 1);
      check("t1_word", popped[0], 8'hA5);
      check("t1_valid_cycles", valid_cycles, 1);
      check("t1_frame_err", got_fe, 0);

      // 2: half-bit glitch is a false start
      hold(1'b0, 16);
      check("t2_busy_during", busy, 1);
      hold(1'b0, 16);
      hold(1'b1, 2 * BIT);
      check("t2_busy_after", busy, 0);
      check("t2_fifo_count", fifo_count, 0);
      check("t2_pop_count", popped.size(), 1);
      check("t2_frame_err", got_fe, 0);

      // 3: stop bit low
      send_frame(8'h3C, 1'b1, 1'b0);
      check("t3_frame_err", got_fe, 1);
      check("t3_fifo_count", fifo_count, 0);
      check("t3_pop_count", popped.size(), 1);

      // 4: overfill with consumer stalled
      set_ready(1'b0);
      popped.delete();
      for (int i = 1; i <= 5; i++)
         send_frame(8'(i), 1'b0, 1'b0);
      check("t4_fifo_full", fifo_count, 4);
      check("t4_overrun", got_ov, 1);
      set_ready(1'b1);
      repeat (10) @(negedge clk);
      check("t4_pop_count", popped.size(), 4);
      for (int i = 0; i < popped.size(); i++)
         check("t4_pop_order", popped[i], 8'(i + 1));
      check("t4_fifo_drained", fifo_count, 0);

`ifdef UART_RX_PARITY_EN
      // 5: even parity, wrong then right parity bit
      popped.delete();
      send_frame(8'h07, 1'b0, 1'b1);
      check("t5_parity_err", got_pe, 1);
      check("t5_no_push", popped.size(), 0);
      send_frame(8'h07, 1'b0, 1'b0);
      check("t5_pushed", popped.size(), 1);
      check("t5_word", popped[0], 8'h07);
`endif

      // 6: reset in the middle of data bit 4, then a clean frame
      hold(1'b0, BIT);
      for (int i = 0; i < 4; i++)
         hold(1'b1, BIT);
      hold(1'b0, BIT / 2);
      check("t6_busy_before", busy, 1);
      rst = 1'b1;
      #1;
      check("t6_busy_reset", busy, 0);
      check("t6_count_reset", fifo_count, 0);
      exp_q.delete();
      rx = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      hold(1'b1, BIT);
      popped.delete();
      send_frame(8'h5A, 1'b0, 1'b0);
      check("t6_pop_count", popped.size(), 1);
      check("t6_word", popped[0], 8'h5A);

      // Whole-run totals against the model
      check("tot_frame_err", got_fe, exp_fe);
      check("tot_parity_err", got_pe, exp_pe);
      check("tot_overrun", got_ov, exp_ov);
      check("tot_undelivered", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
